// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types and constants for the hazard/forwarding control unit.
// Register indices are carried at REG_IDX_W bits; narrower cores zero-extend.
package hazard_fwd_unit_pkg;

  localparam int unsigned REG_IDX_W = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } stage_info_t;

  // True when the stage will write a real (non-x0) register equal to r.
  function automatic logic writes_reg(input stage_info_t s,
                                      input logic [REG_IDX_W-1:0] r);
    return s.valid & s.regwrite & (s.rd != REG_X0) & (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_sel_gen.sv
// Forward-select priority compare for one EX operand: MEM (younger) beats WB,
// otherwise the register file value is used.
module fwd_sel_gen
  import hazard_fwd_unit_pkg::*;
(
  input  logic [REG_IDX_W-1:0] ex_rs_i,
  input  stage_info_t          mem_i,
  input  stage_info_t          wb_i,
  output logic [1:0]           fwd_sel_o
);

  always_comb begin
    fwd_sel_o = FWD_RF;
    if (writes_reg(mem_i, ex_rs_i)) begin
      fwd_sel_o = FWD_MEM;
    end else if (writes_reg(wb_i, ex_rs_i)) begin
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use hazard detection and EX operand forward-select generation, using a
// private shadow pipeline of EX/MEM/WB destination info. Optional macro:
// RF_BYPASS_EN adds WB->ID bypass flags id_byp_a/id_byp_b.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush_ex,
  input  logic              hold,
  output logic              stall_fe,
  output logic              bubble_ex,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel
`ifdef RF_BYPASS_EN
  ,
  output logic              id_byp_a,
  output logic              id_byp_b
`endif
);

  logic [REG_IDX_W-1:0] id_rs1_w, id_rs2_w, id_rd_w;
  stage_info_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [REG_IDX_W-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic                 luh;

  assign id_rs1_w = REG_IDX_W'(id_rs1);
  assign id_rs2_w = REG_IDX_W'(id_rs2);
  assign id_rd_w  = REG_IDX_W'(id_rd);

  // A load in EX whose result an ID source needs cannot be forwarded in time.
  assign luh = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != REG_X0) &
               ((ex_q.rd == id_rs1_w) | (ex_q.rd == id_rs2_w));

  assign stall_fe  = luh | hold;
  assign bubble_ex = (luh | flush_ex) & ~hold;

  always_comb begin
    ex_d     = ex_q;
    ex_rs1_d = ex_rs1_q;
    ex_rs2_d = ex_rs2_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (bubble_ex) begin
        ex_d     = '0;
        ex_rs1_d = '0;
        ex_rs2_d = '0;
      end else begin
        ex_d.valid    = id_valid;
        ex_d.rd       = id_rd_w;
        ex_d.regwrite = id_regwrite;
        ex_d.memread  = id_memread;
        ex_rs1_d      = id_rs1_w;
        ex_rs2_d      = id_rs2_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
    end else begin
      ex_q     <= ex_d;
      ex_rs1_q <= ex_rs1_d;
      ex_rs2_q <= ex_rs2_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
    end
  end

  fwd_sel_gen u_fwd_a (
    .ex_rs_i   (ex_rs1_q),
    .mem_i     (mem_q),
    .wb_i      (wb_q),
    .fwd_sel_o (fwd_a_sel)
  );

  fwd_sel_gen u_fwd_b (
    .ex_rs_i   (ex_rs2_q),
    .mem_i     (mem_q),
    .wb_i      (wb_q),
    .fwd_sel_o (fwd_b_sel)
  );

`ifdef RF_BYPASS_EN
  // For register files that return the old value on a same-cycle write.
  assign id_byp_a = writes_reg(wb_q, id_rs1_w);
  assign id_byp_b = writes_reg(wb_q, id_rs2_w);
`endif

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Control-side counterpart of the EX-stage operand forwarding muxes. It generates the 2-bit selects those 3:1 muxes consume, and detects load-use hazards.
- Holds its own shadow pipeline of destination-register and control info through the EX, MEM and WB stages, so the datapath pipeline registers need not export them.
- Drives stall of PC and IF/ID, bubble insertion into ID/EX, and the forward selects for ALU operands A and B.

Parameters:
- REG_AW, 5, register-index width (x0..x31).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  REG_AW  ID source register 1
- id_rs2  in  REG_AW  ID source register 2
- id_rd  in  REG_AW  ID destination register
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- flush_ex  in  1  branch/jump resolved taken in EX; kill the instruction entering EX
- hold  in  1  global pipeline freeze (memory wait)
- stall_fe  out  1  hold PC and IF/ID this cycle
- bubble_ex  out  1  load zeros/NOP into ID/EX this cycle
- fwd_a_sel  out  2  operand A select: 2'b10 EX/MEM result, 2'b01 MEM/WB result, 2'b00 register file
- fwd_b_sel  out  2  operand B select, same encoding

Behaviour:
- Shadow stages: EX, MEM and WB each hold {valid, rd, regwrite, memread}. EX additionally holds rs1 and rs2.
- Reset: all shadow fields are 0, so stall_fe=0, bubble_ex=0, fwd_a_sel=fwd_b_sel=2'b00 immediately on rst_n low, asynchronously. Reset mid-operation discards all tracked hazards.
- Load-use detect (combinational):
  - luh = id_valid & ex_valid & ex_memread & (ex_rd!=0) & ((ex_rd==id_rs1)|(ex_rd==id_rs2)).
  - stall_fe = luh | hold.
  - bubble_ex = (luh | flush_ex) & ~hold.
- Shadow advance on posedge clk:
  - hold=1: all stages keep their value.
  - Otherwise WB<=MEM and MEM<=EX.
  - EX<=ID fields when bubble_ex=0. EX<=all-zero when bubble_ex=1.
- Forward select (combinational, from shadow EX vs MEM/WB), shown for A; B is identical using ex_rs2:
  - 2'b10 if mem_valid & mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1.
  - Else 2'b01 if wb_valid & wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1.
  - Else 2'b00.
  - MEM has priority over WB; it is the younger producer.
- x0 never forwards and never causes a stall.
- flush_ex together with luh: a single bubble is inserted and stall_fe follows luh. Squashing IF/ID is the front end's job.
- Latency: selects and stalls are combinational from current shadow state. Shadow state updates 1 cycle after ID presentation.
- A load followed by a dependent instruction gives 1 stall cycle, then fwd=2'b01 (load data from MEM/WB).

Optional Feature:
- RF_BYPASS_EN adds outputs id_byp_a and id_byp_b (1 bit each):
  - Each asserts when wb_valid & wb_regwrite & wb_rd!=0 & wb_rd==id_rs1 (resp. id_rs2).
  - Used by register files without write-first behaviour.
- Without the macro these ports do not exist, and WB→ID hazards rely on write-first register-file behaviour.

Decomposition:
- Shared package holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_X0 constant
  - packed stage-info typedef {valid, rd, regwrite, memread}
- One natural sub-module: fwd_sel_gen, the priority compare for one operand, instantiated twice.

Test Plan:
- add x5 in ID, then sub with rs1=x5 next cycle → when sub is in EX, fwd_a_sel=2'b10. One cycle later an instruction with rs2=x5 gets fwd_b_sel=2'b01.
- lw x7, then add with rs2=x7 → stall_fe=1 and bubble_ex=1 for exactly 1 cycle. Then fwd_b_sel=2'b01 when add is in EX.
- Producers writing x3 in both MEM and WB, consumer rs1=x3 → fwd_a_sel=2'b10 (MEM wins).
- lw x0 followed by a consumer with rs1=x0 → no stall, fwd_a_sel=2'b00.
- hold=1 for 3 cycles mid-sequence → shadow stages frozen, fwd selects unchanged, stall_fe=1, bubble_ex=0. Normal progression resumes after hold drops.
- Load-use pending, then rst_n pulsed low asynchronously mid-cycle → all outputs 0 immediately. After release, the first instruction sees fwd=2'b00.
